// File: rtl/orao_pkg.sv
// Shared types and constants for the Orao tape/I-O block.
// The status byte layout lives here so that the decoder and any consumer agree on it.
package orao_pkg;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_PLAY = 2'd1,
    TS_EOT  = 2'd2
  } tape_state_t;

  localparam logic [4:0] KBD_HI   = 5'b10000;
  localparam logic [4:0] AUDIO_HI = 5'b10001;

  localparam int STAT_PLAY_BIT   = 1;
  localparam int STAT_EOT_BIT    = 2;
  localparam int STAT_LOADED_BIT = 3;

  function automatic logic [7:0] stat_byte(input logic loaded, input logic eot, input logic play);
    logic [7:0] s;
    s                  = 8'h00;
    s[STAT_LOADED_BIT] = loaded;
    s[STAT_EOT_BIT]    = eot;
    s[STAT_PLAY_BIT]   = play;
    return s;
  endfunction

endpackage

// File: rtl/orao_tape_io_if.sv
// CPU bus, OSD and ioctl signals of the tape/I-O block, bundled as one interface.
// master drives the bus (CPU/OSD side), slave is the decoder.
interface orao_tape_io_if;

  logic        ce;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  data_out;
  logic [7:0]  kbd_data;
  logic        tape_play;
  logic        tape_rewind;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [1:0]  tape_state;
  logic        audio;

  modport master (
    output ce, addr, we, kbd_data, tape_play, tape_rewind,
           ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  data_out, tape_state, audio
  );

  modport slave (
    input  ce, addr, we, kbd_data, tape_play, tape_rewind,
           ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output data_out, tape_state, audio
  );

endinterface

// File: rtl/orao_tape_buf.sv
// Tape image store: simple dual-port RAM, ioctl writes, playback reads with one clock of latency.
// Left without reset so it maps onto block RAM; contents survive a system reset.
module orao_tape_buf #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [0:(2**ADDR_W)-1];
  logic [7:0] rdata_q;

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/orao_tape_io.sv
// Orao I/O decoder with an ioctl-loaded tape buffer played back as square-wave levels at TAPE_ADDR.
// Each read edge of TAPE_ADDR advances a phase accumulator; '1' bits run twice as long as '0' bits.
module orao_tape_io
  import orao_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int          HALF_SHIFT = 5,
  parameter logic [15:0] TAPE_ADDR  = 16'h87ff,
  parameter logic [15:0] STAT_ADDR  = 16'h87fe,
  parameter logic [7:0]  TAPE_INDEX = 8'd1,
  parameter bit          AUTOPLAY   = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  orao_tape_io_if.slave bus
);

  localparam int PH_W  = HALF_SHIFT + 1;
  localparam int LEN_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = TS_IDLE;
  localparam logic [1:0] S_PLAY = TS_PLAY;
  localparam logic [1:0] S_EOT  = TS_EOT;

  localparam logic [PH_W:0]    PH_STEP_ONE = {{PH_W{1'b0}}, 1'b1};
  localparam logic [PH_W:0]    PH_STEP_TWO = {{(PH_W-1){1'b0}}, 2'b10};
  localparam logic [LEN_W-1:0] LEN_ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO    = {LEN_W{1'b0}};

  logic [1:0]        state_q,  state_d;
  logic              loaded_q, loaded_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic [ADDR_W-1:0] byte_q,   byte_d;
  logic [2:0]        bit_q,    bit_d;
  logic [PH_W-1:0]   phase_q,  phase_d;
  logic [7:0]        data_q,   data_d;
  logic              audio_q,  audio_d;

  logic tape_sel_q;
  logic play_q;
  logic rewind_q;
  logic dl_q;

  logic              tape_sel_s;
  logic              match_s;
  logic              in_range_s;
  logic              wr_en_s;
  logic              dl_fall_s;
  logic              play_rise_s;
  logic              rew_rise_s;
  logic              adv_s;
  logic              cur_bit_s;
  logic              audio_hit_s;
  logic              unused_we_s;
  logic [7:0]        buf_rdata_s;
  logic [LEN_W-1:0]  wr_end_s;
  logic [LEN_W-1:0]  len_base_s;
  logic [LEN_W-1:0]  byte_inc_s;
  logic [PH_W:0]     phase_sum_s;

  orao_tape_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (bus.ioctl_addr[ADDR_W-1:0]),
    .wdata_i (bus.ioctl_dout),
    .raddr_i (byte_q),
    .rdata_o (buf_rdata_s)
  );

  // Audio toggles on reads and writes alike, so the write strobe does not gate it.
  assign unused_we_s = bus.we;

  assign tape_sel_s  = (bus.addr == TAPE_ADDR);
  assign match_s     = bus.ioctl_download && (bus.ioctl_index == TAPE_INDEX);
  assign in_range_s  = ((bus.ioctl_addr >> ADDR_W) == 27'd0);
  assign wr_en_s     = match_s && bus.ioctl_wr && in_range_s;
  assign dl_fall_s   = dl_q && !match_s;
  assign play_rise_s = bus.tape_play && !play_q;
  assign rew_rise_s  = bus.tape_rewind && !rewind_q;
  assign adv_s       = tape_sel_s && !tape_sel_q && (state_q == S_PLAY);
  assign audio_hit_s = bus.ce && (bus.addr[15:11] == AUDIO_HI);

  assign cur_bit_s   = buf_rdata_s[bit_q];
  assign phase_sum_s = {1'b0, phase_q} + (cur_bit_s ? PH_STEP_ONE : PH_STEP_TWO);
  assign byte_inc_s  = {1'b0, byte_q} + LEN_ONE;
  assign wr_end_s    = {1'b0, bus.ioctl_addr[ADDR_W-1:0]} + LEN_ONE;

  // tape FSM, length tracking and playback pointers
  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    len_d      = len_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    // a fresh download starts measuring its length from zero
    len_base_s = dl_q ? len_q : LEN_ZERO;
    if (match_s) begin
      state_d = S_IDLE;
      byte_d  = {ADDR_W{1'b0}};
      bit_d   = 3'd0;
      phase_d = {PH_W{1'b0}};
      if (wr_en_s && (wr_end_s > len_base_s)) begin
        len_d = wr_end_s;
      end else begin
        len_d = len_base_s;
      end
    end else if (dl_fall_s) begin
      loaded_d = 1'b1;
      if (AUTOPLAY && (len_q != LEN_ZERO)) begin
        state_d = S_PLAY;
      end else begin
        state_d = S_IDLE;
      end
    end else if (rew_rise_s) begin
      byte_d  = {ADDR_W{1'b0}};
      bit_d   = 3'd0;
      phase_d = {PH_W{1'b0}};
      if (state_q == S_EOT) begin
        state_d = S_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (play_rise_s) begin
      if ((state_q == S_IDLE) && loaded_q && ({1'b0, byte_q} < len_q)) begin
        state_d = S_PLAY;
      end else if (state_q == S_PLAY) begin
        state_d = S_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (adv_s) begin
      phase_d = phase_sum_s[PH_W-1:0];
      if (phase_sum_s[PH_W]) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          byte_d = byte_inc_s[ADDR_W-1:0];
          if (byte_inc_s == len_q) begin
            state_d = S_EOT;
          end else begin
            state_d = state_q;
          end
        end else begin
          byte_d = byte_q;
        end
      end else begin
        bit_d = bit_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // read data mux and speaker flip-flop
  always_comb begin
    data_d  = 8'hff;
    audio_d = audio_q ^ audio_hit_s;
    if (bus.addr == TAPE_ADDR) begin
      if (state_q == S_PLAY) begin
        data_d = {8{phase_q[PH_W-1]}};
      end else begin
        data_d = 8'h00;
      end
    end else if (bus.addr == STAT_ADDR) begin
      data_d = stat_byte(loaded_q, state_q == S_EOT, state_q == S_PLAY);
    end else if (bus.addr[15:11] == KBD_HI) begin
      data_d = bus.kbd_data;
    end else begin
      data_d = 8'hff;
    end
  end

  // state, pointers, outputs and edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      loaded_q   <= 1'b0;
      len_q      <= LEN_ZERO;
      byte_q     <= {ADDR_W{1'b0}};
      bit_q      <= 3'd0;
      phase_q    <= {PH_W{1'b0}};
      data_q     <= 8'hff;
      audio_q    <= 1'b0;
      tape_sel_q <= 1'b0;
      play_q     <= 1'b0;
      rewind_q   <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      audio_q    <= audio_d;
      tape_sel_q <= tape_sel_s;
      play_q     <= bus.tape_play;
      rewind_q   <= bus.tape_rewind;
      dl_q       <= match_s;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.audio      = audio_q;
  assign bus.tape_state = state_q;

endmodule

// File: tb/tb_orao_tape_io.sv
// Bench for orao_tape_io: directed scenarios plus random traffic, all checked every cycle
// against a bit-duration model of the tape (a '1' bit lasts 64 read edges, a '0' bit 32).
module tb_orao_tape_io;

  logic clk = 1'b0;
  logic reset_n;

  orao_tape_io_if bus_if ();

  orao_tape_io dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tmem [int];
  int         m_len, m_state, m_byte, m_bit, m_cnt;
  bit         m_loaded, m_audio;
  logic [7:0] m_data;
  bit         p_tape, p_play, p_rew, p_match;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_state = 0; m_byte = 0; m_bit = 0; m_cnt = 0;
    m_loaded = 1'b0; m_audio = 1'b0; m_data = 8'hff;
    p_tape = 1'b0; p_play = 1'b0; p_rew = 1'b0; p_match = 1'b0;
  endtask

  // one clock of the reference: output for this cycle's inputs, then the state update
  task automatic model_step();
    logic [7:0] curb;
    bit cur, lvl, match, adv, play_r, rew_r, tape_now;
    int bitlen;
    curb     = tmem.exists(m_byte) ? tmem[m_byte] : 8'h00;
    cur      = curb[m_bit];
    bitlen   = cur ? 64 : 32;
    lvl      = (m_cnt >= bitlen / 2);
    tape_now = (bus_if.addr == 16'h87ff);
    if (tape_now) m_data = (m_state == 1 && lvl) ? 8'hff : 8'h00;
    else if (bus_if.addr == 16'h87fe)
      m_data = 8'((m_loaded ? 8 : 0) + (m_state == 2 ? 4 : 0) + (m_state == 1 ? 2 : 0));
    else if (bus_if.addr >= 16'h8000 && bus_if.addr <= 16'h87ff) m_data = bus_if.kbd_data;
    else m_data = 8'hff;
    if (bus_if.ce && bus_if.addr >= 16'h8800 && bus_if.addr <= 16'h8fff) m_audio = !m_audio;
    match  = bus_if.ioctl_download && (bus_if.ioctl_index == 8'd1);
    play_r = bus_if.tape_play && !p_play;
    rew_r  = bus_if.tape_rewind && !p_rew;
    adv    = tape_now && !p_tape && (m_state == 1);
    if (match) begin
      if (!p_match) m_len = 0;
      if (bus_if.ioctl_wr && bus_if.ioctl_addr < 27'd65536) begin
        tmem[int'(bus_if.ioctl_addr)] = bus_if.ioctl_dout;
        if (int'(bus_if.ioctl_addr) + 1 > m_len) m_len = int'(bus_if.ioctl_addr) + 1;
      end
      m_state = 0; m_byte = 0; m_bit = 0; m_cnt = 0;
    end else if (p_match) begin
      m_loaded = 1'b1;
      m_state  = (m_len != 0) ? 1 : 0;
    end else if (rew_r) begin
      m_byte = 0; m_bit = 0; m_cnt = 0;
      if (m_state == 2) m_state = 0;
    end else if (play_r) begin
      if (m_state == 0 && m_loaded && m_byte < m_len) m_state = 1;
      else if (m_state == 1) m_state = 0;
    end else if (adv) begin
      m_cnt++;
      if (m_cnt == bitlen) begin
        m_cnt = 0;
        m_bit++;
        if (m_bit == 8) begin
          m_bit = 0;
          m_byte++;
          if (m_byte == m_len) m_state = 2;
        end
      end
    end
    p_tape  = tape_now;
    p_play  = bus_if.tape_play;
    p_rew   = bus_if.tape_rewind;
    p_match = match;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check8("data_out", bus_if.data_out, m_data);
    check8("audio", {7'd0, bus_if.audio}, {7'd0, m_audio});
    check8("tape_state", {6'd0, bus_if.tape_state}, 8'(m_state));
  endtask

  task automatic tape_edge(output logic [7:0] lvl);
    bus_if.addr = 16'h87ff;
    tick();
    lvl = bus_if.data_out;
    bus_if.addr = 16'h0000;
    tick();
  endtask

  task automatic dl_byte(input logic [26:0] a, input logic [7:0] d, input logic [7:0] idx);
    bus_if.ioctl_download = 1'b1;
    bus_if.ioctl_index    = idx;
    bus_if.ioctl_wr       = 1'b1;
    bus_if.ioctl_addr     = a;
    bus_if.ioctl_dout     = d;
    tick();
    bus_if.ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic pulse_play();
    bus_if.tape_play = 1'b1;
    tick();
    bus_if.tape_play = 1'b0;
    tick();
  endtask

  task automatic pulse_rewind();
    bus_if.tape_rewind = 1'b1;
    tick();
    bus_if.tape_rewind = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] v;
    reset_n = 1'b0;
    bus_if.ce = 1'b0; bus_if.addr = 16'h0000; bus_if.we = 1'b0; bus_if.kbd_data = 8'h00;
    bus_if.tape_play = 1'b0; bus_if.tape_rewind = 1'b0;
    bus_if.ioctl_download = 1'b0; bus_if.ioctl_index = 8'd0; bus_if.ioctl_wr = 1'b0;
    bus_if.ioctl_addr = 27'd0; bus_if.ioctl_dout = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check8("reset_data", bus_if.data_out, 8'hff);
    check8("reset_audio", {7'd0, bus_if.audio}, 8'h00);
    check8("reset_state", {6'd0, bus_if.tape_state}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // download ff,00 plus one out-of-range byte that must be dropped
    bus_if.ioctl_download = 1'b1;
    bus_if.ioctl_index    = 8'd1;
    tick();
    dl_byte(27'd0, 8'hff, 8'd1);
    dl_byte(27'd1, 8'h00, 8'd1);
    dl_byte(27'h10000, 8'h55, 8'd1);
    bus_if.ioctl_download = 1'b0;
    tick();
    bus_if.addr = 16'h87fe;
    tick();
    check8("stat_after_load", bus_if.data_out, 8'h0a);
    bus_if.addr = 16'h0000;
    tick();

    for (int i = 1; i <= 64; i++) begin
      tape_edge(v);
      if (i == 1 || i == 32) check8("first_half_low", v, 8'h00);
      if (i == 33 || i == 64) check8("second_half_high", v, 8'hff);
    end

    // a held address is a single advance
    bus_if.addr = 16'h87ff;
    repeat (10) tick();
    bus_if.addr = 16'h0000;
    tick();

    bus_if.addr = 16'h8001; bus_if.kbd_data = 8'h5a;
    tick();
    check8("kbd_echo", bus_if.data_out, 8'h5a);
    bus_if.addr = 16'h1234;
    tick();
    check8("unmapped", bus_if.data_out, 8'hff);

    for (int i = 0; i < 35; i++) tape_edge(v);
    pulse_play();
    check8("paused", {6'd0, bus_if.tape_state}, 8'h00);
    for (int i = 0; i < 50; i++) tape_edge(v);
    pulse_play();
    check8("resumed", {6'd0, bus_if.tape_state}, 8'h01);
    tape_edge(v);
    check8("resume_phase", v, 8'hff);
    for (int i = 0; i < 666; i++) tape_edge(v);
    check8("before_eot", {6'd0, bus_if.tape_state}, 8'h01);
    tape_edge(v);
    check8("at_eot", {6'd0, bus_if.tape_state}, 8'h02);
    bus_if.addr = 16'h87fe;
    tick();
    check8("stat_eot", bus_if.data_out, 8'h0c);
    bus_if.addr = 16'h87ff;
    tick();
    check8("eot_level", bus_if.data_out, 8'h00);
    bus_if.addr = 16'h0000;
    tick();

    pulse_rewind();
    check8("rewind_idle", {6'd0, bus_if.tape_state}, 8'h00);
    pulse_play();
    check8("replay", {6'd0, bus_if.tape_state}, 8'h01);
    for (int i = 1; i <= 40; i++) begin
      tape_edge(v);
      if (i == 32) check8("replay_low", v, 8'h00);
      if (i == 33) check8("replay_high", v, 8'hff);
    end

    // rewind wins over an advance in the same cycle
    bus_if.addr = 16'h87ff; bus_if.tape_rewind = 1'b1;
    tick();
    bus_if.addr = 16'h0000; bus_if.tape_rewind = 1'b0;
    tick();
    for (int i = 1; i <= 33; i++) begin
      tape_edge(v);
      if (i == 32) check8("rew_adv_low", v, 8'h00);
      if (i == 33) check8("rew_adv_high", v, 8'hff);
    end

    check8("audio_start", {7'd0, bus_if.audio}, 8'h00);
    bus_if.ce = 1'b1; bus_if.addr = 16'h8800;
    tick(); check8("audio_1", {7'd0, bus_if.audio}, 8'h01);
    tick(); check8("audio_2", {7'd0, bus_if.audio}, 8'h00);
    tick(); check8("audio_3", {7'd0, bus_if.audio}, 8'h01);
    bus_if.ce = 1'b0; bus_if.addr = 16'h0000;
    tick();

    dl_byte(27'd0, 8'h00, 8'd2);
    bus_if.ioctl_download = 1'b0;
    tick();
    check8("other_index", {6'd0, bus_if.tape_state}, 8'h01);

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus_if.addr = 16'h87ff;
        4:          bus_if.addr = 16'h87fe;
        5:          bus_if.addr = 16'h8000 | 16'($urandom_range(0, 16'h07fd));
        6:          bus_if.addr = 16'h8800 | 16'($urandom_range(0, 16'h07ff));
        7:          bus_if.addr = 16'($urandom);
        default:    bus_if.addr = 16'h0000;
      endcase
      bus_if.ce             = 1'($urandom_range(0, 1));
      bus_if.we             = 1'($urandom_range(0, 1));
      bus_if.kbd_data       = 8'($urandom);
      bus_if.tape_play      = ($urandom_range(0, 39) == 0);
      bus_if.tape_rewind    = ($urandom_range(0, 199) == 0);
      bus_if.ioctl_download = ($urandom_range(0, 15) == 0);
      bus_if.ioctl_index    = 8'd2;
      bus_if.ioctl_wr       = 1'($urandom_range(0, 1));
      bus_if.ioctl_addr     = 27'($urandom_range(0, 3));
      bus_if.ioctl_dout     = 8'($urandom);
      tick();
    end
    bus_if.ce = 1'b0; bus_if.we = 1'b0; bus_if.addr = 16'h0000;
    bus_if.tape_play = 1'b0; bus_if.tape_rewind = 1'b0;
    bus_if.ioctl_download = 1'b0; bus_if.ioctl_wr = 1'b0;
    tick();

    pulse_rewind();
    if (m_state == 0) pulse_play();
    check8("pre_reset_play", {6'd0, bus_if.tape_state}, 8'h01);
    if (!m_audio) begin
      bus_if.ce = 1'b1; bus_if.addr = 16'h8800;
      tick();
      bus_if.ce = 1'b0;
    end
    bus_if.addr = 16'h87fe;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check8("async_data", bus_if.data_out, 8'hff);
    check8("async_audio", {7'd0, bus_if.audio}, 8'h00);
    check8("async_state", {6'd0, bus_if.tape_state}, 8'h00);
    model_reset();
    bus_if.addr = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus_if.addr = 16'h87fe;
    tick();
    check8("stat_after_reset", bus_if.data_out, 8'h00);
    bus_if.addr = 16'h0000;
    pulse_play();
    check8("play_refused", {6'd0, bus_if.tape_state}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
